// File: rtl/bus_regs_pkg.sv
// Shared constants, bus payload type and address-map helpers for the register bank.
//   WORD_W       : width of every bus and register word
//   bus_xact_t   : one bus transaction (address, write data, read data, direction, valid)
//   strobe_ofs / sticky_ofs / max_addr : address-map arithmetic derived from N_CFG, N_STAT
package bus_regs_pkg;

  localparam int unsigned WORD_W = 16;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
    logic [WORD_W-1:0] rdata;
    logic              rw;
    logic              valid;
  } bus_xact_t;

  // Strobe register sits right after the status block.
  function automatic int unsigned strobe_ofs(input int unsigned n_cfg, input int unsigned n_stat);
    return n_cfg + n_stat;
  endfunction

  // Sticky register follows the strobe register and is the last owned word.
  function automatic int unsigned sticky_ofs(input int unsigned n_cfg, input int unsigned n_stat);
    return strobe_ofs(n_cfg, n_stat) + 1;
  endfunction

  // Highest owned address, one bit wider so a map near the top of the space cannot wrap.
  function automatic logic [WORD_W:0] max_addr(input logic [WORD_W-1:0] base,
                                               input int unsigned n_cfg,
                                               input int unsigned n_stat);
    return (WORD_W+1)'(base) + (WORD_W+1)'(sticky_ofs(n_cfg, n_stat));
  endfunction

endpackage

// File: rtl/bus_register_bank_if.sv
// Bus segment carrying one transaction per cycle.
//   addr, wdata, rdata : 16-bit address, write data, read data
//   rw, valid          : direction (1 = write) and transaction valid
//   master drives all signals, slave receives all signals
interface bus_register_bank_if;

  logic [bus_regs_pkg::WORD_W-1:0] addr;
  logic [bus_regs_pkg::WORD_W-1:0] wdata;
  logic [bus_regs_pkg::WORD_W-1:0] rdata;
  logic                            rw;
  logic                            valid;

  modport master (output addr, output wdata, output rdata, output rw, output valid);
  modport slave  (input  addr, input  wdata, input  rdata, input  rw, input  valid);

endinterface

// File: rtl/bus_pipe_stage.sv
// One-cycle registered pass-through of a complete bus transaction.
//   clk, rst : clock, asynchronous active-high reset (clears the stage)
//   d_i      : transaction entering the stage
//   q_o      : same transaction one cycle later
module bus_pipe_stage
  import bus_regs_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  bus_xact_t d_i,
  output bus_xact_t q_o
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_o <= '0;
    else     q_o <= d_i;
  end

endmodule

// File: rtl/bus_register_bank.sv
// Register bank sitting inline on a daisy-chained bus: forwards every transaction with one
// cycle of latency and answers reads/writes to its own address window.
//   clk, rst     : clock, asynchronous active-high reset
//   up_i         : upstream bus (slave side)
//   dn_o         : downstream bus (master side); rdata replaced on owned reads
//   cfg_o        : N_CFG read/write config words, word k at [16k+15:16k]
//   cfg_wr_o     : one-cycle pulse per config word written
//   status_i     : N_STAT read-only status words
//   strobe_o     : write-1-to-pulse command bits
//   sticky_set_i : per-bit event inputs; sticky_o holds them until write-1-to-clear
module bus_register_bank
  import bus_regs_pkg::*;
#(
  parameter logic [WORD_W-1:0] BASE_ADDR = 16'h0000,
  parameter int unsigned       N_CFG     = 4,
  parameter int unsigned       N_STAT    = 2,
  parameter logic [WORD_W-1:0] CFG_RESET = 16'h0000
) (
  input  logic                               clk,
  input  logic                               rst,
  bus_register_bank_if.slave                 up_i,
  bus_register_bank_if.master                dn_o,
  output logic [WORD_W*N_CFG-1:0]            cfg_o,
  output logic [N_CFG-1:0]                   cfg_wr_o,
  input  logic [WORD_W*((N_STAT > 0) ? N_STAT : 1)-1:0] status_i,
  output logic [WORD_W-1:0]                  strobe_o,
  input  logic [WORD_W-1:0]                  sticky_set_i,
  output logic [WORD_W-1:0]                  sticky_o
);

  localparam int unsigned    STROBE_OFS = strobe_ofs(N_CFG, N_STAT);
  localparam int unsigned    STICKY_OFS = sticky_ofs(N_CFG, N_STAT);
  localparam logic [WORD_W:0] MAX_ADDR  = max_addr(BASE_ADDR, N_CFG, N_STAT);

  logic [N_CFG-1:0][WORD_W-1:0] cfg_q, cfg_d;
  logic [N_CFG-1:0]             cfg_wr_q, cfg_wr_d;
  logic [WORD_W-1:0]            strobe_q, strobe_d;
  logic [WORD_W-1:0]            sticky_q, sticky_d;
  logic [WORD_W-1:0]            sticky_clr_c;
  logic [WORD_W-1:0]            rdata_sel_c;
  logic [WORD_W-1:0]            ofs_c;
  logic                         hit_c, wr_c, rd_c;
  bus_xact_t                    xact_d, xact_q;

  // Address window decode; compared one bit wide so the top of the space does not wrap.
  always_comb begin
    ofs_c = up_i.addr - BASE_ADDR;
    hit_c = ({1'b0, up_i.addr} >= {1'b0, BASE_ADDR}) && ({1'b0, up_i.addr} <= MAX_ADDR);
    wr_c  = hit_c && up_i.valid && up_i.rw;
    rd_c  = hit_c && up_i.valid && !up_i.rw;
  end

  // Register updates and read-data override for owned addresses.
  always_comb begin
    cfg_d        = cfg_q;
    cfg_wr_d     = '0;
    strobe_d     = '0;
    sticky_clr_c = '0;
    rdata_sel_c  = up_i.rdata;

    for (int k = 0; k < int'(N_CFG); k++) begin
      if (ofs_c == WORD_W'(k)) begin
        if (wr_c) begin
          cfg_d[k]    = up_i.wdata;
          cfg_wr_d[k] = 1'b1;
        end else if (rd_c) begin
          rdata_sel_c = cfg_q[k];
        end
      end
    end

    // Status words are read-only; writes fall through and leave rdata untouched.
    for (int j = 0; j < int'(N_STAT); j++) begin
      if (rd_c && ofs_c == WORD_W'(int'(N_CFG) + j)) rdata_sel_c = status_i[WORD_W*j +: WORD_W];
    end

    if (ofs_c == WORD_W'(STROBE_OFS)) begin
      if (wr_c)      strobe_d    = up_i.wdata;
      else if (rd_c) rdata_sel_c = '0;
    end

    // Sticky read returns the pre-update value.
    if (ofs_c == WORD_W'(STICKY_OFS)) begin
      if (wr_c)      sticky_clr_c = up_i.wdata;
      else if (rd_c) rdata_sel_c  = sticky_q;
    end

    // Set has priority over a same-edge clear.
    sticky_d = (sticky_q & ~sticky_clr_c) | sticky_set_i;

    xact_d.addr  = up_i.addr;
    xact_d.wdata = up_i.wdata;
    xact_d.rdata = rdata_sel_c;
    xact_d.rw    = up_i.rw;
    xact_d.valid = up_i.valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_q    <= {N_CFG{CFG_RESET}};
      cfg_wr_q <= '0;
      strobe_q <= '0;
      sticky_q <= '0;
    end else begin
      cfg_q    <= cfg_d;
      cfg_wr_q <= cfg_wr_d;
      strobe_q <= strobe_d;
      sticky_q <= sticky_d;
    end
  end

  bus_pipe_stage u_pipe (
    .clk (clk),
    .rst (rst),
    .d_i (xact_d),
    .q_o (xact_q)
  );

  assign dn_o.addr  = xact_q.addr;
  assign dn_o.wdata = xact_q.wdata;
  assign dn_o.rdata = xact_q.rdata;
  assign dn_o.rw    = xact_q.rw;
  assign dn_o.valid = xact_q.valid;

  assign cfg_o    = cfg_q;
  assign cfg_wr_o = cfg_wr_q;
  assign strobe_o = strobe_q;
  assign sticky_o = sticky_q;

endmodule

// File: tb/tb_bus_register_bank.sv
// Bench for bus_register_bank: directed scenarios plus randomized traffic, all checked
// against a behavioural model of the register map.
module tb_bus_register_bank;

  localparam logic [15:0] BASE = 16'h0010;
  localparam int          NC   = 4;
  localparam int          NS   = 2;
  localparam logic [15:0] CRST = 16'h5A5A;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] cfg;
  logic [3:0]  cfg_wr;
  logic [31:0] status;
  logic [15:0] strobe;
  logic [15:0] sticky_set;
  logic [15:0] sticky;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] cfg_m [NC];
  logic [15:0] sticky_m;

  bus_register_bank_if up_if ();
  bus_register_bank_if dn_if ();

  bus_register_bank #(
    .BASE_ADDR (BASE),
    .N_CFG     (NC),
    .N_STAT    (NS),
    .CFG_RESET (CRST)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .up_i         (up_if.slave),
    .dn_o         (dn_if.master),
    .cfg_o        (cfg),
    .cfg_wr_o     (cfg_wr),
    .status_i     (status),
    .strobe_o     (strobe),
    .sticky_set_i (sticky_set),
    .sticky_o     (sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_cfg();
    logic [63:0] v;
    for (int k = 0; k < NC; k++) v[16*k +: 16] = cfg_m[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NC; k++) cfg_m[k] = CRST;
    sticky_m = '0;
  endtask

  // Predict from the register-map rules, clock once, compare every output.
  task automatic step();
    int          ofs;
    logic [15:0] e_rdata, e_strobe, clr, s_addr, s_wdata;
    logic [3:0]  e_wr;
    logic        wr, rd, s_rw, s_valid;
    s_addr  = up_if.addr;
    s_wdata = up_if.wdata;
    s_rw    = up_if.rw;
    s_valid = up_if.valid;
    ofs      = int'(s_addr) - int'(BASE);
    wr       = s_valid && s_rw;
    rd       = s_valid && !s_rw;
    e_rdata  = up_if.rdata;
    e_strobe = '0;
    e_wr     = '0;
    clr      = '0;
    if (ofs >= 0 && ofs < NC) begin
      if (wr) begin
        cfg_m[ofs] = s_wdata;
        e_wr[ofs]  = 1'b1;
      end else if (rd) begin
        e_rdata = cfg_m[ofs];
      end
    end else if (ofs >= NC && ofs < NC + NS) begin
      if (rd) e_rdata = status[16*(ofs-NC) +: 16];
    end else if (ofs == NC + NS) begin
      if (wr) e_strobe = s_wdata;
      else if (rd) e_rdata = '0;
    end else if (ofs == NC + NS + 1) begin
      if (wr) clr = s_wdata;
      else if (rd) e_rdata = sticky_m;
    end
    sticky_m = (sticky_m & ~clr) | sticky_set;
    @(posedge clk);
    #1;
    chk("addr_o",   64'(dn_if.addr),  64'(s_addr));
    chk("wdata_o",  64'(dn_if.wdata), 64'(s_wdata));
    chk("rdata_o",  64'(dn_if.rdata), 64'(e_rdata));
    chk("rw_o",     64'(dn_if.rw),    64'(s_rw));
    chk("valid_o",  64'(dn_if.valid), 64'(s_valid));
    chk("cfg_o",    cfg,              model_cfg());
    chk("cfg_wr_o", 64'(cfg_wr),      64'(e_wr));
    chk("strobe_o", 64'(strobe),      64'(e_strobe));
    chk("sticky_o", 64'(sticky),      64'(sticky_m));
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] wd, input logic [15:0] rd_in,
                       input logic r_w, input logic v);
    up_if.addr  = a;
    up_if.wdata = wd;
    up_if.rdata = rd_in;
    up_if.rw    = r_w;
    up_if.valid = v;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    drive(a, d, 16'($urandom), 1'b1, 1'b1);
    step();
  endtask

  task automatic bus_rd(input logic [15:0] a, input logic [15:0] rd_in);
    drive(a, 16'($urandom), rd_in, 1'b0, 1'b1);
    step();
  endtask

  task automatic idle();
    drive(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    step();
  endtask

  initial begin
    // Reset behaviour, with events pending that must be ignored.
    rst        = 1'b1;
    status     = 32'h1234_8765;
    sticky_set = 16'hFFFF;
    drive(16'h0011, 16'h1111, 16'h2222, 1'b1, 1'b1);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_valid_o", 64'(dn_if.valid), 64'h0);
    chk("rst_addr_o",  64'(dn_if.addr),  64'h0);
    chk("rst_rdata_o", 64'(dn_if.rdata), 64'h0);
    chk("rst_cfg_o",   cfg,              {4{CRST}});
    chk("rst_cfg_wr",  64'(cfg_wr),      64'h0);
    chk("rst_strobe",  64'(strobe),      64'h0);
    chk("rst_sticky",  64'(sticky),      64'h0);
    sticky_set = '0;
    drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    rst = 1'b0;
    idle();

    // Config write then read back.
    bus_wr(16'h0012, 16'hBEEF);
    chk("cfg2_word",  64'(cfg[47:32]), 64'hBEEF);
    chk("cfg2_pulse", 64'(cfg_wr),     64'h4);
    bus_rd(16'h0012, 16'h0000);
    chk("cfg2_read",  64'(dn_if.rdata), 64'hBEEF);
    chk("cfg2_nopulse", 64'(cfg_wr),    64'h0);

    // Back-to-back strobe writes, then a strobe read.
    bus_wr(16'h0016, 16'h0005);
    chk("strobe_1", 64'(strobe), 64'h5);
    bus_wr(16'h0016, 16'h0005);
    chk("strobe_2", 64'(strobe), 64'h5);
    bus_rd(16'h0016, 16'hAAAA);
    chk("strobe_off",  64'(strobe),      64'h0);
    chk("strobe_read", 64'(dn_if.rdata), 64'h0);

    // Sticky set, write-1-to-clear, set-wins, pre-update read.
    sticky_set = 16'h0003;
    idle();
    chk("sticky_set", 64'(sticky), 64'h3);
    sticky_set = 16'h0000;
    bus_wr(16'h0017, 16'h0001);
    chk("sticky_clr", 64'(sticky), 64'h2);
    sticky_set = 16'h0002;
    bus_wr(16'h0017, 16'h0002);
    chk("sticky_setwins", 64'(sticky), 64'h2);
    sticky_set = 16'h0004;
    bus_rd(16'h0017, 16'h0000);
    chk("sticky_read_old", 64'(dn_if.rdata), 64'h2);
    chk("sticky_after",    64'(sticky),      64'h6);
    sticky_set = 16'h0000;

    // Status read and ignored status write.
    bus_rd(16'h0015, 16'h0000);
    chk("status1_read", 64'(dn_if.rdata), 64'h1234);
    drive(16'h0015, 16'hFFFF, 16'h7777, 1'b1, 1'b1);
    step();
    chk("status_wr_rdata", 64'(dn_if.rdata), 64'h7777);
    chk("status_wr_cfg",   64'(cfg_wr),      64'h0);

    // Out-of-range read passes through.
    bus_rd(16'h0000, 16'hCAFE);
    chk("oor_rdata", 64'(dn_if.rdata), 64'hCAFE);
    chk("oor_addr",  64'(dn_if.addr),  64'h0);

    // Randomized traffic concentrated around the owned window.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      if ($urandom_range(0, 15) < 12) a = 16'h000C + 16'($urandom_range(0, 15));
      else a = 16'($urandom);
      drive(a, 16'($urandom), 16'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
      sticky_set = ($urandom_range(0, 3) == 0) ? 16'(1 << $urandom_range(0, 15)) : 16'h0;
      if ($urandom_range(0, 7) == 0) status = $urandom;
      step();
    end
    sticky_set = '0;

    // Asynchronous reset in the middle of a config write.
    bus_wr(16'h0011, 16'h4321);
    drive(16'h0013, 16'h1111, 16'h0, 1'b1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cfg_now",   cfg,              {4{CRST}});
    chk("arst_valid_now", 64'(dn_if.valid), 64'h0);
    chk("arst_sticky",    64'(sticky),      64'h0);
    model_reset();
    @(posedge clk);
    #1;
    chk("arst_cfg_hold", cfg, {4{CRST}});
    drive(16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    rst = 1'b0;
    idle();
    chk("arst_no_pulse", 64'(cfg_wr), 64'h0);
    chk("arst_cfg_post", cfg,         {4{CRST}});
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
